// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream multiplexer and its arbiter.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_t;

  // A single channel still needs a one-bit index so port widths never collapse to zero.
  function automatic int calc_cw(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or after ptr.
module rr_arbiter import mux_pkg::*; #(
  parameter  int NUM_CH = 4,
  localparam int CW     = calc_cw(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     idx
);

  // Walk the channels cyclically from ptr; the first request seen wins.
  always_comb begin
    int   ch;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    ch    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch = (int'(ptr) + k) % NUM_CH;
      if (!found && req[ch]) begin
        found     = 1'b1;
        grant[ch] = 1'b1;
        idx       = CW'(ch);
      end
    end
  end

endmodule

// File: rtl/simple_stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a single registered output slot,
// selecting by an external sel or by round-robin arbitration.
module simple_stream_mux import mux_pkg::*; #(
  parameter  int        WIDTH  = 8,
  parameter  int        NUM_CH = 4,
  parameter  mux_mode_t MODE   = MUX_FIXED,
  localparam int        CW     = calc_cw(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     sel,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [WIDTH-1:0]  in_data [NUM_CH],
  output logic [NUM_CH-1:0] in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [CW-1:0]     out_ch,
  input  logic              out_ready
);

  logic [CW-1:0]     ptr;
  logic [NUM_CH-1:0] rr_grant;
  logic [CW-1:0]     rr_idx;
  logic [NUM_CH-1:0] grant;
  logic [CW-1:0]     grant_idx;
  logic              can_load;
  logic              accept;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Fixed mode compares sel against every channel so an out-of-range sel grants nothing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (MODE == MUX_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(sel) == i) begin
          grant[i]  = in_valid[i];
          grant_idx = CW'(i);
        end
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  assign accept   = !rst && can_load && (|grant);
  assign in_ready = (rst || !can_load) ? '0 : grant;

  // A new word overwrites the slot even while the old one leaves, giving one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The pointer only moves on an accept, landing just past the channel that was served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == MUX_RR && accept) begin
      ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_simple_stream_mux.sv
// Self-checking bench: fixed-select and round-robin muxes driven side by side,
// plus a three-channel fixed mux for the out-of-range select case.
module tb_simple_stream_mux;
  import mux_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [W-1:0]  in_data [N];
  logic          out_ready;

  logic [N-1:0]  rdy_f, rdy_r;
  logic          ov_f, ov_r;
  logic [W-1:0]  od_f, od_r;
  logic [CW-1:0] oc_f, oc_r;

  logic [2:0]    in_valid3;
  logic [W-1:0]  in_data3 [3];
  logic [2:0]    rdy_3;
  logic          ov_3;
  logic [W-1:0]  od_3;
  logic [1:0]    oc_3;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = fixed mux, index 1 = round-robin mux.
  bit       m_v [2];
  bit [7:0] m_d [2];
  int       m_c [2];
  int       m_ptr;

  always #5 clk = ~clk;

  assign in_valid3   = in_valid[2:0];
  assign in_data3[0] = in_data[0];
  assign in_data3[1] = in_data[1];
  assign in_data3[2] = in_data[2];

  simple_stream_mux #(.WIDTH(W), .NUM_CH(N), .MODE(MUX_FIXED)) u_fix (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_f), .out_valid(ov_f), .out_data(od_f), .out_ch(oc_f), .out_ready(out_ready)
  );

  simple_stream_mux #(.WIDTH(W), .NUM_CH(N), .MODE(MUX_RR)) u_rr (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_r), .out_valid(ov_r), .out_data(od_r), .out_ch(oc_r), .out_ready(out_ready)
  );

  simple_stream_mux #(.WIDTH(W), .NUM_CH(3), .MODE(MUX_FIXED)) u_fix3 (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(rdy_3), .out_valid(ov_3), .out_data(od_3), .out_ch(oc_3), .out_ready(out_ready)
  );

  // Channel chosen this cycle by the given mux, or -1 when nobody is chosen.
  function automatic int exp_grant(input int m);
    if (m == 0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit [N-1:0] exp_ready(input int m);
    int g;
    g = exp_grant(m);
    if ((m_v[m] && !out_ready) || g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 1'b0;
      m_d[m] = '0;
      m_c[m] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_tick();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = exp_grant(m);
      if ((!m_v[m] || out_ready) && g >= 0) begin
        m_v[m] = 1'b1;
        m_d[m] = in_data[g];
        m_c[m] = g;
        if (m == 1) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_v[m] = 1'b0;
      end
    end
  endtask

  task automatic clear_inputs();
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #2 rst = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({ov_f, od_f, oc_f} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_fix_out: got %b/%h/%0d expected 0/00/0", ov_f, od_f, oc_f);
    end
    n_checks++;
    if ({ov_r, od_r, oc_r} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_rr_out: got %b/%h/%0d expected 0/00/0", ov_r, od_r, oc_r);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rdy_f, rdy_r, rdy_3} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_in_ready: got %b %b %b expected all zero", rdy_f, rdy_r, rdy_3);
    end
    n_checks++;
    if (ov_r !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_held_valid: got %b expected 0", ov_r);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_fixed_select();
    do_reset();
    @(negedge clk);
    sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    in_data[0] = 8'h11; in_data[1] = 8'h22; in_data[2] = 8'hA5; in_data[3] = 8'h44;
    #1;
    n_checks++;
    if (rdy_f !== 4'b0100) begin
      n_fail++; $display("[TB] FAIL fixed_ready: got %b expected 0100", rdy_f);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov_f !== 1'b1 || od_f !== 8'hA5 || oc_f !== 2'd2) begin
      n_fail++; $display("[TB] FAIL fixed_out: got %b/%h/%0d expected 1/a5/2", ov_f, od_f, oc_f);
    end
    n_checks++;
    if (ov_3 !== 1'b1 || od_3 !== 8'hA5 || oc_3 !== 2'd2) begin
      n_fail++; $display("[TB] FAIL fixed3_out: got %b/%h/%0d expected 1/a5/2", ov_3, od_3, oc_3);
    end
    @(negedge clk);
    sel = 2'd3;
    #1;
    n_checks++;
    if (rdy_f !== 4'b1000) begin
      n_fail++; $display("[TB] FAIL fixed_sel_change: got %b expected 1000", rdy_f);
    end
    n_checks++;
    if (rdy_3 !== 3'b000) begin
      n_fail++; $display("[TB] FAIL fixed3_sel_range: got %b expected 000", rdy_3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov_3 !== 1'b0 || od_3 !== 8'hA5 || oc_3 !== 2'd2) begin
      n_fail++; $display("[TB] FAIL fixed3_drain: got %b/%h/%0d expected 0/a5/2", ov_3, od_3, oc_3);
    end
    n_checks++;
    if (od_f !== 8'h44 || oc_f !== 2'd3) begin
      n_fail++; $display("[TB] FAIL fixed_back_to_back: got %h/%0d expected 44/3", od_f, oc_f);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    do_reset();
    @(negedge clk);
    in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = W'(8'h10 + i);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov_r !== 1'b1 || int'(oc_r) != exp_ch[i] || od_r !== in_data[exp_ch[i]]) begin
        n_fail++;
        $display("[TB] FAIL rr_wrap[%0d]: got %b/%0d/%h expected 1/%0d/%h",
                 i, ov_r, oc_r, od_r, exp_ch[i], in_data[exp_ch[i]]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int         exp_ch  [3] = '{3, 1, 3};
    logic [3:0] exp_rdy [3] = '{4'b1000, 4'b0010, 4'b1000};
    do_reset();
    @(negedge clk);
    in_valid = 4'b0010; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = W'(8'h60 + i);
    @(posedge clk); #1;
    n_checks++;
    if (oc_r !== 2'd1) begin
      n_fail++; $display("[TB] FAIL rr_sparse_setup: got %0d expected 1", oc_r);
    end
    @(negedge clk);
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (rdy_r !== exp_rdy[i]) begin
        n_fail++; $display("[TB] FAIL rr_sparse_ready[%0d]: got %b expected %b", i, rdy_r, exp_rdy[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (int'(oc_r) != exp_ch[i] || od_r !== in_data[exp_ch[i]]) begin
        n_fail++; $display("[TB] FAIL rr_sparse[%0d]: got %0d/%h expected %0d", i, oc_r, od_r, exp_ch[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1; in_data[1] = 8'h3C;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 4'hF;
      for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
      #1;
      n_checks++;
      if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL stall_ready[%0d]: got %b %b expected 0000", c, rdy_f, rdy_r);
      end
      n_checks++;
      if (ov_f !== 1'b1 || od_f !== 8'h3C || oc_f !== 2'd1 || od_r !== 8'h3C || oc_r !== 2'd1) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: got %b/%h/%0d rr %h/%0d expected 1/3c/1", c, ov_f, od_f, oc_f, od_r, oc_r);
      end
    end
    @(negedge clk);
    out_ready  = 1'b1;
    in_data[1] = 8'h5A;
    in_data[2] = 8'hC3;
    #1;
    n_checks++;
    if (rdy_f !== 4'b0010 || rdy_r !== 4'b0100) begin
      n_fail++; $display("[TB] FAIL stall_release_ready: got %b %b expected 0010 0100", rdy_f, rdy_r);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov_f !== 1'b1 || od_f !== 8'h5A || oc_r !== 2'd2 || od_r !== 8'hC3) begin
      n_fail++; $display("[TB] FAIL stall_release_load: got %b/%h rr %0d/%h expected 1/5a rr 2/c3", ov_f, od_f, oc_r, od_r);
    end
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    @(negedge clk);
    sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1; in_data[1] = 8'h77;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 4'b0110;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ov_f, od_f, oc_f, ov_r, od_r, oc_r} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_stall_out: got %b/%h/%0d rr %b/%h/%0d expected zeros", ov_f, od_f, oc_f, ov_r, od_r, oc_r);
    end
    n_checks++;
    if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_stall_ready: got %b %b expected 0000", rdy_f, rdy_r);
    end
    @(negedge clk);
    rst = 1'b0;
    in_data[1] = 8'h81;
    #1;
    n_checks++;
    if (rdy_r !== 4'b0010) begin
      n_fail++; $display("[TB] FAIL reset_stall_first_grant: got %b expected 0010", rdy_r);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov_r !== 1'b1 || oc_r !== 2'd1 || od_r !== 8'h81) begin
      n_fail++; $display("[TB] FAIL reset_stall_first_word: got %b/%0d/%h expected 1/1/81", ov_r, oc_r, od_r);
    end
  endtask

  task automatic test_random();
    bit [N-1:0] er;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (m == 0 ? (ov_f !== m_v[0] || od_f !== m_d[0] || int'(oc_f) != m_c[0])
                   : (ov_r !== m_v[1] || od_r !== m_d[1] || int'(oc_r) != m_c[1])) begin
          n_fail++;
          $display("[TB] FAIL random_out[%0d] mux%0d: got %b/%h/%0d expected %b/%h/%0d", cyc, m,
                   m == 0 ? ov_f : ov_r, m == 0 ? od_f : od_r, m == 0 ? oc_f : oc_r, m_v[m], m_d[m], m_c[m]);
        end
      end
      sel       = CW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
      #1;
      er = exp_ready(0);
      n_checks++;
      if (rdy_f !== er) begin
        n_fail++; $display("[TB] FAIL random_ready_fix[%0d]: got %b expected %b", cyc, rdy_f, er);
      end
      er = exp_ready(1);
      n_checks++;
      if (rdy_r !== er) begin
        n_fail++; $display("[TB] FAIL random_ready_rr[%0d]: got %b expected %b", cyc, rdy_r, er);
      end
      model_tick();
    end
  endtask

  initial begin
    test_reset();
    test_fixed_select();
    test_rr_wrap();
    test_rr_sparse();
    test_stall();
    test_reset_in_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_stream_mux.md
SIMPLE_STREAM_MUX -- requirements
Module: simple_stream_mux

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, >= 1.
REQ-002 Parameter NUM_CH, default 4: number of input channels, >= 1; CW = max(1, $clog2(NUM_CH)).
REQ-003 Parameter MODE, default MUX_FIXED: arbitration mode, type mux_mode_t; MUX_FIXED uses sel; MUX_RR uses round-robin.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sel  input  CW  channel select, used only in MUX_FIXED.
REQ-007 in_valid  input  NUM_CH  per-channel data valid.
REQ-008 in_data  input  NUM_CH x WIDTH  per-channel data, unpacked array [NUM_CH].
REQ-009 in_ready  output  NUM_CH  per-channel accept; a transfer on channel i occurs when in_valid[i] && in_ready[i] at a rising edge.
REQ-010 out_valid  output  1  registered output holds a word.
REQ-011 out_data  output  WIDTH  registered word.
REQ-012 out_ch  output  CW  source channel of out_data.
REQ-013 out_ready  input  1  downstream accept; output transfer when out_valid && out_ready.

Function
REQ-014 Output stage is one register slot; can_load = !out_valid || out_ready (combinational).
REQ-015 grant is one-hot or zero, combinational from in_valid, sel/pointer; in_ready[i] = can_load && grant[i]; at most one in_ready high per cycle.
REQ-016 Latency: word accepted at edge k is on out_data with out_valid=1 immediately after edge k (1 cycle).
REQ-017 On accept: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
REQ-018 Output transfer with no accept in same cycle: out_valid <= 0; out_data, out_ch hold last value.
REQ-019 Stall: while out_valid && !out_ready, out_valid, out_data, out_ch are stable and all in_ready are 0.
REQ-020 Simultaneous output transfer and accept: new word replaces old in same edge; full throughput, one word per cycle, no bubble.
REQ-021 MUX_FIXED: grant[sel] = in_valid[sel]; all other grants 0; sel >= NUM_CH grants nothing; sel change takes effect combinationally for the next edge.
REQ-022 MUX_RR: state ptr (CW bits, 0..NUM_CH-1); grant goes to first valid channel searching ptr, ptr+1, ... cyclically mod NUM_CH.
REQ-023 MUX_RR: after accept from channel g, ptr <= (g+1) mod NUM_CH, with wrap NUM_CH-1 -> 0; ptr unchanged when no accept (including stall).
REQ-024 No channel valid: no grant, ptr unchanged; out_valid falls after pending word is consumed.
REQ-025 NUM_CH = 1: channel 0 always granted when valid; ptr constant 0; out_ch constant 0.
REQ-026 in_data of non-granted channels never affects outputs.

Reset
REQ-027 While rst = 1: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, all in_ready = 0 (forced, independent of clk).
REQ-028 Reset mid-stall discards the held word; no transfer is counted on the edge where rst deasserts.

Structure
REQ-029 Package mux_pkg holds mux_mode_t (MUX_FIXED, MUX_RR) and a function computing CW from NUM_CH.
REQ-030 Sub-module rr_arbiter (parameter NUM_CH): inputs req, ptr; output one-hot grant and encoded index; purely combinational; ptr register stays in simple_stream_mux.
REQ-031 Estimated size 150-250 RTL lines total.

Verification
REQ-032 MUX_FIXED, NUM_CH=4, sel=2, in_valid=4'b1111, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_ch=2; in_ready=4'b0100.
REQ-033 MUX_RR, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles (ptr wrap).
REQ-034 MUX_RR, only ch1 and ch3 valid from ptr=2 -> out_ch sequence 3,1,3; ptr after each = 0,2,0.
REQ-035 Accept 8'h3C then hold out_ready=0 for 5 cycles with new inputs valid -> out_data stays 3C, in_ready=0, ptr unchanged; release -> 3C transferred and next word loads on same edge.
REQ-036 Assert rst during stall with out_valid=1 -> out_valid, out_data, out_ch, in_ready go 0 without a clock edge; after release, ptr=0, first grant to lowest valid channel.
